// File: rtl/alb_pkg.sv
// Shared constants and operation encoding for the alb_unit datapath stage.
package alb_pkg;

   localparam int ALB_WIDTH = 10;

   typedef enum logic [1:0] {
      OP_NOR_OR = 2'b00,
      OP_ADD    = 2'b01,
      OP_XNOR   = 2'b10,
      OP_SUB    = 2'b11
   } alb_op_e;

endpackage

// File: rtl/alb_if.sv
// Operand/result bundle of alb_unit. The master drives operands, the slave (alb_unit) returns results.
interface alb_if
   import alb_pkg::*;
#(
   parameter int WIDTH = ALB_WIDTH,
   parameter int SHW   = $clog2(WIDTH)
);
   // Handshake: valid-only, no ready. A beat transfers on every rising edge where
   // in_valid=1; out_valid is in_valid delayed by one edge. Results hold while idle.
   logic             in_valid;
   logic [WIDTH-1:0] R;
   logic [WIDTH-1:0] S;
   logic             CI;
   logic [1:0]       sel;
   logic             normalize_en;

   logic             out_valid;
   logic [WIDTH-1:0] F;
   logic [WIDTH-1:0] normalized_F;
   logic [SHW-1:0]   shift;
   logic             CO;
   logic             VO;
   logic             NO;
   logic             ZO;

   modport master (
      output in_valid, R, S, CI, sel, normalize_en,
      input  out_valid, F, normalized_F, shift, CO, VO, NO, ZO
   );

   modport slave (
      input  in_valid, R, S, CI, sel, normalize_en,
      output out_valid, F, normalized_F, shift, CO, VO, NO, ZO
   );
endinterface

// File: rtl/alb_normalizer.sv
// Combinational leading-zero normalizer: shifts the input left until its MSB is set.
module normalizer #(
   parameter int WIDTH = 10,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] in,
   input  logic             enable,
   output logic [WIDTH-1:0] out,
   output logic [SHW-1:0]   shift
);
   logic [SHW-1:0] lz;
   logic           found;

   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (in[i]) found = 1'b1;
            else       lz    = lz + SHW'(1);
         end
      end
      // An all-zero input leaves the value untouched and reports no shift.
      if (enable && found) begin
         out   = in << lz;
         shift = lz;
      end else begin
         out   = in;
         shift = '0;
      end
   end
endmodule

// File: rtl/alb_unit.sv
// Registered 10-bit arithmetic/logic stage with NZCV flags; the leading-zero
// normalizer on the result is built only when ALB_NORMALIZER_EN is defined.
module alb_unit
   import alb_pkg::*;
#(
   parameter int WIDTH = ALB_WIDTH,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic  clk,
   input logic  rst,
   alb_if.slave bus
);
   alb_op_e          op;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] f_next;
   logic             co_next;
   logic             vo_next;
   logic [WIDTH-1:0] norm_next;
   logic [SHW-1:0]   shift_next;

   assign op = alb_op_e'(bus.sel);

   // Subtract is R + ~S + CI, so overflow is judged on R and the inverted S.
   always_comb begin
      addend  = (op == OP_SUB) ? ~bus.S : bus.S;
      sum     = {1'b0, bus.R} + {1'b0, addend} + {{WIDTH{1'b0}}, bus.CI};
      f_next  = sum[WIDTH-1:0];
      co_next = sum[WIDTH];
      vo_next = (bus.R[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != bus.R[WIDTH-1]);
      case (op)
         OP_NOR_OR: begin
            f_next  = ~bus.R | bus.S;
            co_next = 1'b0;
            vo_next = 1'b0;
         end
         OP_XNOR: begin
            f_next  = ~(bus.R ^ bus.S);
            co_next = 1'b0;
            vo_next = 1'b0;
         end
         default: ;
      endcase
   end

`ifdef ALB_NORMALIZER_EN
   normalizer #(.WIDTH(WIDTH), .SHW(SHW)) u_normalizer (
      .in     (f_next),
      .enable (bus.normalize_en),
      .out    (norm_next),
      .shift  (shift_next)
   );
`else
   wire unused_normalize_en = bus.normalize_en;
   assign norm_next  = f_next;
   assign shift_next = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid    <= 1'b0;
         bus.F            <= '0;
         bus.normalized_F <= '0;
         bus.shift        <= '0;
         bus.CO           <= 1'b0;
         bus.VO           <= 1'b0;
         bus.NO           <= 1'b0;
         bus.ZO           <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.F            <= f_next;
            bus.normalized_F <= norm_next;
            bus.shift        <= shift_next;
            bus.CO           <= co_next;
            bus.VO           <= vo_next;
            bus.NO           <= f_next[WIDTH-1];
            bus.ZO           <= (f_next == '0);
         end
      end
   end
endmodule

// File: tb/tb_alb_unit.sv
// Self-checking bench for alb_unit: reference model feeds an expected queue, results popped one cycle later.
module tb_alb_unit;
   localparam int W   = 10;
   localparam int SHW = 4;
   localparam int EW  = 2 * W + SHW + 4;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] last_exp;

   alb_if #(.WIDTH(W), .SHW(SHW)) bus ();

   alb_unit #(.WIDTH(W), .SHW(SHW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sx(input logic [W-1:0] x);
      return x[W-1] ? int'(x) - (1 << W) : int'(x);
   endfunction

   // Reference model; packs {F, normalized_F, shift, CO, VO, NO, ZO}.
   function automatic logic [EW-1:0] model(input logic [1:0] sel, input logic [W-1:0] r,
                                           input logic [W-1:0] s, input logic ci, input logic ne);
      int             u;
      int             sres;
      logic [W-1:0]   f;
      logic [W-1:0]   nf;
      logic [SHW-1:0] sh;
      logic           c;
      logic           v;
      c = 1'b0;
      v = 1'b0;
      u = 0;
      sres = 0;
      case (sel)
         2'b00: f = ~r | s;
         2'b10: f = ~(r ^ s);
         2'b01: begin
            u    = int'(r) + int'(s) + int'(ci);
            sres = sx(r) + sx(s) + int'(ci);
         end
         default: begin
            u    = int'(r) + ((1 << W) - 1 - int'(s)) + int'(ci);
            sres = sx(r) - sx(s) - 1 + int'(ci);
         end
      endcase
      if (sel[0]) begin
         f = u[W-1:0];
         c = (u >= (1 << W));
         v = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
      end
      nf = f;
      sh = '0;
`ifdef ALB_NORMALIZER_EN
      if (ne && f != '0) begin
         while (!nf[W-1]) begin
            nf = nf << 1;
            sh = sh + 1'b1;
         end
      end
`else
      if (ne) sh = '0;
`endif
      return {f, nf, sh, c, v, f[W-1], (f == '0)};
   endfunction

   task automatic check_outputs(input string tag, input logic [EW-1:0] e);
      check_eq({tag, ".F"},     32'(bus.F), 32'(e[EW-1 -: W]));
      check_eq({tag, ".normF"}, 32'(bus.normalized_F), 32'(e[EW-W-1 -: W]));
      check_eq({tag, ".shift"}, 32'(bus.shift), 32'(e[7:4]));
      check_eq({tag, ".CVNZ"},  32'({bus.CO, bus.VO, bus.NO, bus.ZO}), 32'(e[3:0]));
   endtask

   // driver: one beat per cycle, outputs checked #1 after the sampling edge
   task automatic do_op(input string tag, input logic valid, input logic [1:0] sel,
                        input logic [W-1:0] r, input logic [W-1:0] s, input logic ci, input logic ne);
      logic [EW-1:0] e;
      @(negedge clk);
      bus.in_valid     = valid;
      bus.sel          = sel;
      bus.R            = r;
      bus.S            = s;
      bus.CI           = ci;
      bus.normalize_en = ne;
      if (valid) exp_q.push_back(model(sel, r, s, ci, ne));
      @(posedge clk);
      #1;
      check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'(valid));
      if (valid) begin
         if (exp_q.size() == 0) begin
            check_eq({tag, ".queue"}, 32'(0), 32'(1));
            e = last_exp;
         end else begin
            e = exp_q.pop_front();
         end
         last_exp = e;
      end else begin
         e = last_exp;
      end
      check_outputs(tag, e);
   endtask

   task automatic randomize_inputs();
      bus.in_valid     = 1'b1;
      bus.sel          = 2'($urandom_range(0, 3));
      bus.R            = W'($urandom_range(0, (1 << W) - 1));
      bus.S            = W'($urandom_range(0, (1 << W) - 1));
      bus.CI           = 1'($urandom_range(0, 1));
      bus.normalize_en = 1'($urandom_range(0, 1));
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      last_exp = '0;
      rst      = 1'b1;
      randomize_inputs();

      // reset with random inputs active
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset.out_valid", 32'(bus.out_valid), 32'(0));
      check_outputs("reset", '0);
      @(negedge clk);
      rst = 1'b0;

      do_op("first",       1'b1, 2'b01, 10'b0000000001, 10'b0000000001, 1'b0, 1'b0);
      do_op("or_nonorm",   1'b1, 2'b00, 10'b1100110011, 10'b1010101010, 1'b0, 1'b0);
      do_op("or_norm",     1'b1, 2'b00, 10'b1100110011, 10'b1010101010, 1'b0, 1'b1);
      do_op("add_nonorm",  1'b1, 2'b01, 10'b0000001111, 10'b0000000001, 1'b1, 1'b0);
      do_op("add_norm",    1'b1, 2'b01, 10'b0000001111, 10'b0000000001, 1'b1, 1'b1);
      do_op("xnor",        1'b1, 2'b10, 10'b1111000011, 10'b1010101010, 1'b0, 1'b0);
      do_op("sub_nonorm",  1'b1, 2'b11, 10'b1000000000, 10'b0000001111, 1'b1, 1'b0);
      do_op("sub_norm",    1'b1, 2'b11, 10'b1000000000, 10'b0000001111, 1'b1, 1'b1);
      do_op("idle_hold",   1'b0, 2'b01, 10'b0101010101, 10'b0011001100, 1'b1, 1'b1);
      do_op("add_zero",    1'b1, 2'b01, 10'b1111111111, 10'b0000000000, 1'b1, 1'b0);
      do_op("add_zero_n",  1'b1, 2'b01, 10'b1111111111, 10'b0000000000, 1'b1, 1'b1);
      do_op("add_ovf",     1'b1, 2'b01, 10'b0111111111, 10'b0000000001, 1'b0, 1'b1);
      do_op("sub_borrow",  1'b1, 2'b11, 10'b0000000011, 10'b0000000101, 1'b1, 1'b1);
      do_op("norm_lsb",    1'b1, 2'b01, 10'b0000000000, 10'b0000000001, 1'b0, 1'b1);

      for (int i = 0; i < 60; i++) begin
         do_op("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // asynchronous reset mid-operation discards the in-flight beat
      do_op("pre_rst", 1'b1, 2'b00, 10'b0000000000, 10'b1111111111, 1'b0, 1'b0);
      @(negedge clk);
      randomize_inputs();
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst.out_valid", 32'(bus.out_valid), 32'(0));
      check_outputs("midrst", '0);
      @(posedge clk);
      #1;
      check_outputs("midrst_hold", '0);
      @(negedge clk);
      rst      = 1'b0;
      last_exp = '0;
      exp_q.delete();
      do_op("post_rst", 1'b1, 2'b11, 10'b0000000101, 10'b0000000101, 1'b1, 1'b1);

      check_eq("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
